// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchroniser, 4-state stability FSM, registered level and
// press/release strobes. Optional press counter enabled by defining BTN_PRESS_COUNT_EN;
// without it press_count is tied to 0 and no counter flops exist.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] StReleased    = 2'd0;
    localparam logic [1:0] StPressWait   = 2'd1;
    localparam logic [1:0] StHeld        = 2'd2;
    localparam logic [1:0] StReleaseWait = 2'd3;

    logic            btn_norm;
    logic [1:0]      sync_q, sync_d;
    logic            raw_s;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            btn_level_q, btn_level_d;
    logic            press_pulse_q, press_pulse_d;
    logic            release_pulse_q, release_pulse_d;

    // Pressed is always 1 from here on, whatever the board wiring.
    assign btn_norm = ACTIVE_LOW ? ~btn_in : btn_in;
    assign raw_s    = sync_q[1];

    // Shift the normalised button into the two-stage synchroniser.
    always_comb begin
        sync_d = {sync_q[0], btn_norm};
    end

    // Stability FSM: counter is cleared on every transition so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StReleased: begin
                if (raw_s) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!raw_s) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!raw_s) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (raw_s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        btn_level_d     = (state_d == StHeld) || (state_d == StReleaseWait);
        press_pulse_d   = (state_q == StPressWait) && (state_d == StHeld);
        release_pulse_d = (state_q == StReleaseWait) && (state_d == StReleased);
    end

    // Synchroniser, FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q          <= 2'b00;
            state_q         <= StReleased;
            cnt_q           <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count_q, press_count_d;

    // Count moves together with press_pulse; wraps naturally at 8 bits.
    always_comb begin
        press_count_d = press_pulse_d ? press_count_q + 8'd1 : press_count_q;
    end

    // Press counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_count_q <= 8'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign press_count = press_count_q;
`else
    assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer (DEBOUNCE_CYCLES=4). Two instances share one stimulus:
// one active-low, one active-high fed the complementary pin level, so both must match
// the same behavioural model. Honours BTN_PRESS_COUNT_EN for press_count expectations.
module tb_button_debouncer;

    localparam int unsigned Deb = 4;
`ifdef BTN_PRESS_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       btn_lo_in;
    logic       btn_hi_in;
    logic       lvl_lo, press_lo, release_lo;
    logic       lvl_hi, press_hi, release_hi;
    logic [7:0] count_lo, count_hi;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Behavioural model: the button as seen after two clock edges of sync delay; the
    // accepted level flips once Deb+1 consecutive samples disagree with it.
    logic       cur_pressed;
    logic [1:0] m_pipe;
    logic       m_level;
    int         m_streak;
    logic       m_press, m_release;
    logic [7:0] m_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES(Deb),
        .ACTIVE_LOW     (1'b1)
    ) u_dut_lo (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_lo_in),
        .btn_level    (lvl_lo),
        .press_pulse  (press_lo),
        .release_pulse(release_lo),
        .press_count  (count_lo)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(Deb),
        .ACTIVE_LOW     (1'b0)
    ) u_dut_hi (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_hi_in),
        .btn_level    (lvl_hi),
        .press_pulse  (press_hi),
        .release_pulse(release_hi),
        .press_count  (count_hi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe    = 2'b00;
        m_level   = 1'b0;
        m_streak  = 0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_count   = 8'd0;
    endtask

    task automatic model_edge();
        logic seen;
        if (rst) begin
            model_reset();
        end else begin
            seen      = m_pipe[1];
            m_pipe    = {m_pipe[0], cur_pressed};
            m_press   = 1'b0;
            m_release = 1'b0;
            if (seen != m_level) begin
                m_streak++;
                if (m_streak == Deb + 1) begin
                    m_level  = ~m_level;
                    m_streak = 0;
                    if (m_level) begin
                        m_press = 1'b1;
                        m_count = m_count + 8'd1;
                    end else begin
                        m_release = 1'b1;
                    end
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_cnt;
        exp_cnt = CountEn ? m_count : 8'd0;
        check("lo_level",   {7'd0, lvl_lo},     {7'd0, m_level});
        check("lo_press",   {7'd0, press_lo},   {7'd0, m_press});
        check("lo_release", {7'd0, release_lo}, {7'd0, m_release});
        check("lo_count",   count_lo,           exp_cnt);
        check("hi_level",   {7'd0, lvl_hi},     {7'd0, m_level});
        check("hi_press",   {7'd0, press_hi},   {7'd0, m_press});
        check("hi_release", {7'd0, release_hi}, {7'd0, m_release});
        check("hi_count",   count_hi,           exp_cnt);
    endtask

    // Drive one cycle from a negedge: set pins, take the edge, update model, check.
    task automatic step(input logic pressed);
        cur_pressed = pressed;
        btn_lo_in   = ~pressed;
        btn_hi_in   = pressed;
        @(posedge clk);
        edge_cnt++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step(cur_pressed);
        rst = 1'b0;
    endtask

    initial begin
        int start;
        int lat;
        int pulses;
        logic v;
        int len;

        rst         = 1'b1;
        cur_pressed = 1'b0;
        btn_lo_in   = 1'b1;
        btn_hi_in   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        repeat (3) step(1'b0);

        // Clean press: strobe must appear 7 edges after the pin change.
        start = edge_cnt;
        lat   = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (press_lo === 1'b1 && lat == 0) lat = edge_cnt - start;
        end
        check("press_latency", 8'(lat), 8'd7);

        // Clean release.
        start = edge_cnt;
        lat   = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            if (release_lo === 1'b1 && lat == 0) lat = edge_cnt - start;
        end
        check("release_latency", 8'(lat), 8'd7);

        // Bounce shorter than the window: never accepted.
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1);
                pulses += int'(press_lo) + int'(release_lo) + int'(lvl_lo);
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b0);
                pulses += int'(press_lo) + int'(release_lo) + int'(lvl_lo);
            end
        end
        check("bounce_activity", 8'(pulses), 8'd0);

        // Random runs of mixed lengths around the debounce window.
        for (int r = 0; r < 80; r++) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) step(v);
        end
        repeat (10) step(1'b0);

        // Reset while in PRESS_WAIT with button held, then a fresh full-latency press.
        repeat (4) step(1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) step(1'b1);
        rst   = 1'b0;
        start = edge_cnt;
        lat   = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (press_lo === 1'b1 && lat == 0) lat = edge_cnt - start;
        end
        check("reset_press_latency", 8'(lat), 8'd7);
        repeat (10) step(1'b0);

        // 256 presses from a clean reset: count reaches 255 then wraps to 0.
        cur_pressed = 1'b0;
        do_reset();
        for (int p = 1; p <= 256; p++) begin
            repeat (8) step(1'b1);
            repeat (8) step(1'b0);
            if (p == 255) check("count_at_255", count_lo, CountEn ? 8'd255 : 8'd0);
        end
        check("count_wrapped", count_lo, 8'd0);
        check("count_wrapped_hi", count_hi, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
